// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall/flush/freeze control for a 5-stage in-order pipeline.
// Handles load-use stalls, taken-branch flushes from MEM and data-memory freezes,
// with a sticky watchdog that flags a memory access hung for 255 cycles.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall_count / flush_count outputs.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic [4:0] rt_ex,
  input  logic       ctrl_MemRead_ex,
  input  logic       branch_taken_mem,
  input  logic       mem_access_mem,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       pc_src_branch,
  output logic [1:0] state_o,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] wait_cnt_r;
  logic       mem_timeout_r;
  logic       freeze_s;
  logic       load_use_s;
  logic       stall_evt_s;
  logic       flush_evt_s;

  // Hazard detection: memory freeze and load-use dependency on the ID sources.
  always_comb begin
    freeze_s   = mem_access_mem & ~mem_ready;
    load_use_s = ctrl_MemRead_ex & (rt_ex != 5'd0) &
                 ((rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id)));
  end

  // Resolve priority freeze > branch > load-use; ID holds a bubble in BR_FLUSH so load-use is ignored there.
  always_comb begin
    flush_evt_s = 1'b0;
    stall_evt_s = 1'b0;
    if (rst || freeze_s) begin
      flush_evt_s = 1'b0;
      stall_evt_s = 1'b0;
    end else if (branch_taken_mem) begin
      flush_evt_s = 1'b1;
    end else if (load_use_s && (state_r != ST_BR_FLUSH)) begin
      stall_evt_s = 1'b1;
    end else begin
      flush_evt_s = 1'b0;
      stall_evt_s = 1'b0;
    end
  end

  // State register with synchronous reset; reset drops any pending flush or wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: freeze dominates, a taken branch (including on the release cycle) enters BR_FLUSH.
  always_comb begin
    state_next_s = ST_RUN;
    case (state_r)
      ST_RUN, ST_MEM_WAIT, ST_BR_FLUSH: begin
        if (freeze_s) begin
          state_next_s = ST_MEM_WAIT;
        end else if (branch_taken_mem) begin
          state_next_s = ST_BR_FLUSH;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Output logic: zero-latency enables/flushes decoded from the resolved hazard.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    pc_src_branch = 1'b0;
    if (rst || freeze_s) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (flush_evt_s) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      pc_src_branch = 1'b1;
    end else if (stall_evt_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // Freeze watchdog: counts consecutive freeze cycles, saturating, and latches a sticky timeout at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else if (!freeze_s) begin
      wait_cnt_r <= 8'd0;
    end else begin
      if (wait_cnt_r != 8'd255) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (wait_cnt_r == 8'd254) begin
        mem_timeout_r <= 1'b1;
      end
    end
  end

  assign state_o     = state_r;
  assign mem_timeout = mem_timeout_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating performance counters for load-use stall cycles and branch flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (stall_evt_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (flush_evt_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`endif

endmodule
